mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 8, memory address width in bits.
REQ-002 Parameter DATA_W, default 8, memory data width in bits.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; 0 = in reset.
REQ-005 r0_req, r0_we  input  1 each  CPU load/store request, write-enable.
REQ-006 r0_addr  input  ADDR_W  CPU address.
REQ-007 r0_wdata  input  DATA_W  CPU store data.
REQ-008 r0_gnt, r0_rvalid  output  1 each  CPU grant pulse, read-data-valid pulse.
REQ-009 r0_rdata  output  DATA_W  CPU load data.
REQ-010 r1_req, r1_we, r1_addr, r1_wdata, r1_gnt, r1_rvalid, r1_rdata  as REQ-005..009, program-loader/debug port.
REQ-011 mem_en, mem_we  output  1 each  single-port memory access strobe, write-enable.
REQ-012 mem_addr  output  ADDR_W, mem_wdata  output  DATA_W  memory address/write data.
REQ-013 mem_rdata  input  DATA_W  memory read data, valid the cycle after a read strobe.

Function
REQ-014 FSM states SHALL be IDLE and RD_WAIT only.
REQ-015 In IDLE with any rN_req=1, exactly one port SHALL be granted that cycle: rN_gnt=1, mem_en=1, mem_we/addr/wdata driven from the winner.
REQ-016 Requester SHALL hold req/we/addr/wdata stable until it sees gnt; arbiter samples them only in the gnt cycle.
REQ-017 Tie (both req=1): winner = port named by priority register prio; lone requester always wins.
REQ-018 After any grant to port N, prio SHALL point to the other port (round-robin); prio unchanged on idle cycles.
REQ-019 Write grant: FSM stays IDLE; a new grant is allowed the very next cycle (back-to-back writes at 1/cycle).
REQ-020 Read grant in cycle N: FSM -> RD_WAIT; in cycle N+1 rN_rvalid=1, rN_rdata=mem_rdata, no grant issued, mem_en=0; FSM -> IDLE.
REQ-021 Read throughput SHALL be one read per 2 cycles; read latency gnt->rvalid exactly 1 cycle.
REQ-022 rvalid SHALL assert only for the port that issued the read; the other port's rvalid stays 0.
REQ-023 When not driving rvalid, rN_rdata SHALL be 0.
REQ-024 All outputs other than the listed strobes SHALL be 0 when mem_en=0 (mem_we, mem_addr, mem_wdata = 0).
REQ-025 Requests arriving during RD_WAIT SHALL wait; they are arbitrated in the following IDLE cycle using current prio.

Reset
REQ-026 reset=0 SHALL immediately force state=IDLE, prio=r0, and all outputs 0 (gnt, rvalid, mem_en included, regardless of req).
REQ-027 Reset asserted during RD_WAIT SHALL abort the read: no rvalid is ever produced for it after release.
REQ-028 First rising edge after reset=1 SHALL allow normal arbitration.

Structure
REQ-029 Package cpu_pkg SHALL hold arb_state_t (IDLE, RD_WAIT) and default ADDR_W/DATA_W constants.
REQ-030 Sub-module rr_pick (2-way combinational round-robin picker: req[1:0], prio -> onehot grant) SHALL be used; FSM, prio register and muxing stay in mem_arbiter.

Verification
REQ-031 Reset, then r0 write addr 0x10 data 0xA5 -> r0_gnt=1, mem_en=1, mem_we=1, mem_addr=0x10, mem_wdata=0xA5 same cycle; next cycle free.
REQ-032 r1 read addr 0x10, memory model returns 0xA5 -> r1_gnt cycle N, r1_rvalid=1 and r1_rdata=0xA5 in N+1, r0_rvalid=0.
REQ-033 Both req=1 continuously with writes after reset -> grants alternate r0,r1,r0,r1 on consecutive cycles.
REQ-034 Both req=1 with reads -> r0 gnt N, rvalid N+1, r1 gnt N+2, rvalid N+3; no grant in N+1, N+3.
REQ-035 reset=0 asserted in RD_WAIT after r0 read of 0x20 -> outputs 0 immediately; after release, r0_rvalid never pulses without a new grant.
REQ-036 r0 req=1 held for 4 cycles with r1 idle -> r0 granted every write cycle; prio toggles to r1 each time.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and default widths for the memory arbiter slice.
package cpu_pkg;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } arb_state_t;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;

endpackage

// File: rtl/rr_pick.sv
// Two-way combinational round-robin picker: a lone requester always wins,
// a tie goes to the port named by prio (0 = r0, 1 = r1).
module rr_pick (
  input  logic [1:0] req,
  input  logic       prio,
  output logic [1:0] gnt
);

  assign gnt[0] = req[0] & (~req[1] | ~prio);
  assign gnt[1] = req[1] & (~req[0] |  prio);

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-port memory: writes at one per cycle,
// reads take a grant cycle plus one read-data cycle.
//
// state   | meaning
// IDLE    | arbitrate; a grant drives the memory strobe this cycle
// RD_WAIT | memory returns read data; route it to the reading port, no grant
module mem_arbiter
  import cpu_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_gnt,
  output logic              r0_rvalid,
  output logic [DATA_W-1:0] r0_rdata,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_gnt,
  output logic              r1_rvalid,
  output logic [DATA_W-1:0] r1_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_t        state_q, state_d;
  logic              prio_q, prio_d;
  logic              rd_port_q, rd_port_d;
  logic [1:0]        pick;
  logic [1:0]        gnt_vec;
  logic              win;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  rr_pick u_pick (
    .req  ({r1_req, r0_req}),
    .prio (prio_q),
    .gnt  (pick)
  );

  // Gating with reset keeps every output low while reset is held, even
  // though the grant path is combinational from the request inputs.
  assign gnt_vec   = (state_q == IDLE && reset) ? pick : 2'b00;
  assign win       = gnt_vec[1];
  assign sel_we    = win ? r1_we    : r0_we;
  assign sel_addr  = win ? r1_addr  : r0_addr;
  assign sel_wdata = win ? r1_wdata : r0_wdata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      prio_q    <= 1'b0;
      rd_port_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      prio_q    <= prio_d;
      rd_port_q <= rd_port_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    prio_d    = prio_q;
    rd_port_d = rd_port_q;
    case (state_q)
      IDLE: begin
        if (|gnt_vec) begin
          prio_d = ~win;
          if (!sel_we) begin
            state_d   = RD_WAIT;
            rd_port_d = win;
          end
        end
      end
      RD_WAIT: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    r0_gnt    = gnt_vec[0];
    r1_gnt    = gnt_vec[1];
    r0_rvalid = 1'b0;
    r1_rvalid = 1'b0;
    r0_rdata  = '0;
    r1_rdata  = '0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (|gnt_vec) begin
      mem_en    = 1'b1;
      mem_we    = sel_we;
      mem_addr  = sel_addr;
      mem_wdata = sel_wdata;
    end
    if (state_q == RD_WAIT && reset) begin
      if (rd_port_q) begin
        r1_rvalid = 1'b1;
        r1_rdata  = mem_rdata;
      end else begin
        r0_rvalid = 1'b1;
        r0_rdata  = mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural single-port memory.
module tb_mem_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       r0_req, r0_we, r1_req, r1_we;
  logic [7:0] r0_addr, r0_wdata, r1_addr, r1_wdata;
  logic       r0_gnt, r0_rvalid, r1_gnt, r1_rvalid;
  logic [7:0] r0_rdata, r1_rdata;
  logic       mem_en, mem_we;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0] mem [256];

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .r0_req    (r0_req),
    .r0_we     (r0_we),
    .r0_addr   (r0_addr),
    .r0_wdata  (r0_wdata),
    .r0_gnt    (r0_gnt),
    .r0_rvalid (r0_rvalid),
    .r0_rdata  (r0_rdata),
    .r1_req    (r1_req),
    .r1_we     (r1_we),
    .r1_addr   (r1_addr),
    .r1_wdata  (r1_wdata),
    .r1_gnt    (r1_gnt),
    .r1_rvalid (r1_rvalid),
    .r1_rdata  (r1_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_reqs();
    r0_req = 0; r0_we = 0; r0_addr = 0; r0_wdata = 0;
    r1_req = 0; r1_we = 0; r1_addr = 0; r1_wdata = 0;
  endtask

  task automatic quiet_outputs(input string tag);
    chk({tag, "_r0_gnt"},    r0_gnt,    0);
    chk({tag, "_r1_gnt"},    r1_gnt,    0);
    chk({tag, "_r0_rvalid"}, r0_rvalid, 0);
    chk({tag, "_r1_rvalid"}, r1_rvalid, 0);
    chk({tag, "_mem_en"},    mem_en,    0);
    chk({tag, "_mem_addr"},  mem_addr,  0);
  endtask

  initial begin
    reset = 0;
    idle_reqs();
    r0_req = 1; r1_req = 1; r0_addr = 8'h44; r1_addr = 8'h55;
    #2;
    quiet_outputs("in_reset");
    idle_reqs();
    #10 reset = 1;
    tick();

    // single write, then the very next cycle is free for another write
    r0_req = 1; r0_we = 1; r0_addr = 8'h10; r0_wdata = 8'hA5;
    #2;
    chk("wr_r0_gnt", r0_gnt, 1);
    chk("wr_r1_gnt", r1_gnt, 0);
    chk("wr_mem_en", mem_en, 1);
    chk("wr_mem_we", mem_we, 1);
    chk("wr_mem_addr", mem_addr, 8'h10);
    chk("wr_mem_wdata", mem_wdata, 8'hA5);
    tick();
    r0_addr = 8'h11; r0_wdata = 8'h3C;
    #2;
    chk("wr2_r0_gnt", r0_gnt, 1);
    chk("wr2_mem_addr", mem_addr, 8'h11);
    tick();
    idle_reqs();
    #2;
    quiet_outputs("idle1");
    chk("idle1_mem_wdata", mem_wdata, 0);

    // r1 reads back the value r0 stored
    r1_req = 1; r1_we = 0; r1_addr = 8'h10;
    #2;
    chk("rd_r1_gnt", r1_gnt, 1);
    chk("rd_mem_en", mem_en, 1);
    chk("rd_mem_we", mem_we, 0);
    chk("rd_mem_addr", mem_addr, 8'h10);
    tick();
    idle_reqs();
    #2;
    chk("rd_r1_rvalid", r1_rvalid, 1);
    chk("rd_r1_rdata", r1_rdata, 8'hA5);
    chk("rd_r0_rvalid", r0_rvalid, 0);
    chk("rd_r0_rdata", r0_rdata, 0);
    chk("rd_wait_mem_en", mem_en, 0);
    tick();
    #2;
    chk("rd_done_r1_rvalid", r1_rvalid, 0);
    chk("rd_done_r1_rdata", r1_rdata, 0);

    // fresh reset, then both ports write continuously: grants alternate from r0
    reset = 0;
    #1;
    reset = 1;
    r0_req = 1; r0_we = 1; r0_addr = 8'h30; r0_wdata = 8'h01;
    r1_req = 1; r1_we = 1; r1_addr = 8'h31; r1_wdata = 8'h02;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("alt%0d_r0_gnt", i), r0_gnt, (i % 2 == 0) ? 1 : 0);
      chk($sformatf("alt%0d_r1_gnt", i), r1_gnt, (i % 2 == 1) ? 1 : 0);
      chk($sformatf("alt%0d_mem_addr", i), mem_addr, (i % 2 == 0) ? 8'h30 : 8'h31);
      tick();
    end

    // both ports read: one read per two cycles, prio back at r0
    r0_we = 0; r1_we = 0;
    #2;
    chk("rr_n_r0_gnt", r0_gnt, 1);
    chk("rr_n_r1_gnt", r1_gnt, 0);
    tick();
    r0_req = 0;
    #2;
    chk("rr_n1_r0_rvalid", r0_rvalid, 1);
    chk("rr_n1_r0_rdata", r0_rdata, 8'h01);
    chk("rr_n1_r1_rvalid", r1_rvalid, 0);
    chk("rr_n1_r1_gnt", r1_gnt, 0);
    chk("rr_n1_mem_en", mem_en, 0);
    tick();
    #2;
    chk("rr_n2_r1_gnt", r1_gnt, 1);
    chk("rr_n2_mem_addr", mem_addr, 8'h31);
    chk("rr_n2_r0_rvalid", r0_rvalid, 0);
    tick();
    r1_req = 0;
    r0_req = 1; r0_we = 1; r0_addr = 8'h20; r0_wdata = 8'h5A;
    #2;
    chk("rr_n3_r1_rvalid", r1_rvalid, 1);
    chk("rr_n3_r1_rdata", r1_rdata, 8'h02);
    chk("rr_n3_r0_rvalid", r0_rvalid, 0);
    chk("rr_n3_r0_gnt_held", r0_gnt, 0);
    tick();
    #2;
    chk("rr_n4_r0_gnt", r0_gnt, 1);
    chk("rr_n4_mem_we", mem_we, 1);
    tick();
    idle_reqs();

    // reset while a read is outstanding aborts it
    r0_req = 1; r0_we = 0; r0_addr = 8'h20;
    #2;
    chk("ab_r0_gnt", r0_gnt, 1);
    tick();
    idle_reqs();
    #1 reset = 0;
    #1;
    chk("ab_r0_rvalid", r0_rvalid, 0);
    chk("ab_r0_rdata", r0_rdata, 0);
    chk("ab_mem_en", mem_en, 0);
    tick();
    reset = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("ab_after%0d_r0_rvalid", i), r0_rvalid, 0);
      chk($sformatf("ab_after%0d_r0_gnt", i), r0_gnt, 0);
    end

    // lone r0 requester granted every cycle; prio ends on r1
    r0_req = 1; r0_we = 1; r0_addr = 8'h40; r0_wdata = 8'h77;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("lone%0d_r0_gnt", i), r0_gnt, 1);
      chk($sformatf("lone%0d_r1_gnt", i), r1_gnt, 0);
      tick();
    end
    r1_req = 1; r1_we = 1; r1_addr = 8'h41; r1_wdata = 8'h88;
    #1;
    chk("tie_after_lone_r1_gnt", r1_gnt, 1);
    chk("tie_after_lone_r0_gnt", r0_gnt, 0);
    chk("tie_after_lone_mem_addr", mem_addr, 8'h41);
    tick();
    idle_reqs();
    #2;
    quiet_outputs("final");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
